// File: rtl/jtframe_sdram64_arb4.sv
// Four-client round-robin arbiter in front of one jtframe_sdram64 bank port.
// Latency: bank request registered one cycle after a request is sampled; ack/dok/rdy are routed back combinationally.
// Backpressure: one outstanding transaction; clients hold until c_ack; a watchdog releases a bank that never returns rdy.
module jtframe_sdram64_arb4 #(
    parameter int         AW      = 22,
    parameter logic [3:0] WR_MASK = 4'b1111,
    parameter int         TIMEOUT = 1023
) (
    input  logic            clk,
    input  logic            rst,
    // client side
    input  logic [4*AW-1:0] c_addr,
    input  logic [3:0]      c_rd,
    input  logic [3:0]      c_wr,
    input  logic [63:0]     c_din,
    input  logic [7:0]      c_din_m,
    output logic [3:0]      c_ack,
    output logic [3:0]      c_dok,
    output logic [3:0]      c_rdy,
    // bank side
    output logic [AW-1:0]   ba_addr,
    output logic            ba_rd,
    output logic            ba_wr,
    output logic [15:0]     ba_din,
    output logic [1:0]      ba_din_m,
    input  logic            ba_ack,
    input  logic            ba_dok,
    input  logic            ba_rdy,
    // status
    output logic [3:0]      gnt,
    output logic            timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // The watchdog counter is 10 bits wide, so the limit is truncated to that.
    localparam logic [9:0] TIMEOUT_L = 10'(TIMEOUT);

    state_t          state_q;
    logic [3:0]      gnt_q;
    logic [1:0]      gidx_q;
    logic [1:0]      ptr_q;
    logic [9:0]      cnt_q;
    logic            timeout_err_q;
    logic [AW-1:0]   ba_addr_q;
    logic            ba_rd_q;
    logic            ba_wr_q;
    logic [15:0]     ba_din_q;
    logic [1:0]      ba_din_m_q;

    logic [3:0]      req;
    logic            pick_vld;
    logic [1:0]      pick_idx;
    logic [1:0]      cand;
    logic            pick_wr;
    logic [AW-1:0]   pick_addr;
    logic [15:0]     pick_din;
    logic [1:0]      pick_din_m;
    logic            timeout_hit;

    // Round-robin pick: the scan runs from the farthest candidate back to ptr so the nearest requester is kept.
    always_comb begin
        req      = c_rd | c_wr;
        pick_vld = 1'b0;
        pick_idx = ptr_q;
        cand     = ptr_q;
        for (int i = 3; i >= 0; i--) begin
            cand = ptr_q + 2'(i);
            if (req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    // Operand mux for the picked client; a write without its WR_MASK bit degrades to a read.
    always_comb begin
        pick_addr  = '0;
        pick_din   = '0;
        pick_din_m = '0;
        for (int i = 0; i < 4; i++) begin
            if (pick_idx == 2'(i)) begin
                pick_addr  = c_addr[i*AW +: AW];
                pick_din   = c_din[i*16 +: 16];
                pick_din_m = c_din_m[i*2 +: 2];
            end
        end
        pick_wr = c_wr[pick_idx] & WR_MASK[pick_idx];
    end

    // Watchdog fires only in WAIT and only if the bank has not answered in the same cycle.
    always_comb begin
        timeout_hit = (state_q == ST_WAIT) && !ba_rdy && (cnt_q == TIMEOUT_L);
    end

    // Bank strobes are forwarded to the granted client only, and only in the phase they belong to.
    always_comb begin
        c_ack = '0;
        c_dok = '0;
        c_rdy = '0;
        if (state_q == ST_ISSUE) begin
            c_ack = gnt_q & {4{ba_ack}};
        end
        if (state_q == ST_WAIT) begin
            c_dok = gnt_q & {4{ba_dok}};
            c_rdy = gnt_q & {4{ba_rdy | timeout_hit}};
        end
    end

    // Arbiter FSM: IDLE grants and latches operands, ISSUE waits for ack, WAIT waits for rdy or the watchdog.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            gnt_q         <= '0;
            gidx_q        <= '0;
            ptr_q         <= '0;
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
            ba_addr_q     <= '0;
            ba_rd_q       <= 1'b0;
            ba_wr_q       <= 1'b0;
            ba_din_q      <= '0;
            ba_din_m_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_vld) begin
                        gnt_q      <= 4'b0001 << pick_idx;
                        gidx_q     <= pick_idx;
                        ba_addr_q  <= pick_addr;
                        ba_din_q   <= pick_din;
                        ba_din_m_q <= pick_din_m;
                        ba_wr_q    <= pick_wr;
                        ba_rd_q    <= !pick_wr;
                        state_q    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // No watchdog here: the bank may legitimately stall for refresh.
                    if (ba_ack) begin
                        ba_rd_q <= 1'b0;
                        ba_wr_q <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (ba_rdy || timeout_hit) begin
                        ptr_q   <= gidx_q + 2'd1;
                        gnt_q   <= '0;
                        state_q <= ST_IDLE;
                        if (timeout_hit) begin
                            timeout_err_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 10'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    gnt_q   <= '0;
                    ba_rd_q <= 1'b0;
                    ba_wr_q <= 1'b0;
                end
            endcase
        end
    end

    assign gnt         = gnt_q;
    assign timeout_err = timeout_err_q;
    assign ba_addr     = ba_addr_q;
    assign ba_rd       = ba_rd_q;
    assign ba_wr       = ba_wr_q;
    assign ba_din      = ba_din_q;
    assign ba_din_m    = ba_din_m_q;

endmodule

// File: tb/tb_jtframe_sdram64_arb4.sv
// Directed bench for jtframe_sdram64_arb4 with a grant scoreboard.
// Inputs change on the falling edge; registered outputs are sampled there, combinational ones 1 ns later.
// The DUT uses WR_MASK=4'b0001 and TIMEOUT=16 so masking and the watchdog can be reached quickly.
module tb_jtframe_sdram64_arb4;
    localparam int AW = 22;

    logic            clk = 1'b0;
    logic            rst;
    logic [4*AW-1:0] c_addr;
    logic [3:0]      c_rd;
    logic [3:0]      c_wr;
    logic [63:0]     c_din;
    logic [7:0]      c_din_m;
    logic [3:0]      c_ack;
    logic [3:0]      c_dok;
    logic [3:0]      c_rdy;
    logic [AW-1:0]   ba_addr;
    logic            ba_rd;
    logic            ba_wr;
    logic [15:0]     ba_din;
    logic [1:0]      ba_din_m;
    logic            ba_ack;
    logic            ba_dok;
    logic            ba_rdy;
    logic [3:0]      gnt;
    logic            timeout_err;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0]    gnt;
        logic [AW-1:0] addr;
        logic          wr;
        logic [15:0]   din;
        logic [1:0]    dm;
    } exp_t;

    exp_t sb[$];

    jtframe_sdram64_arb4 #(
        .AW      (AW),
        .WR_MASK (4'b0001),
        .TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .c_addr      (c_addr),
        .c_rd        (c_rd),
        .c_wr        (c_wr),
        .c_din       (c_din),
        .c_din_m     (c_din_m),
        .c_ack       (c_ack),
        .c_dok       (c_dok),
        .c_rdy       (c_rdy),
        .ba_addr     (ba_addr),
        .ba_rd       (ba_rd),
        .ba_wr       (ba_wr),
        .ba_din      (ba_din),
        .ba_din_m    (ba_din_m),
        .ba_ack      (ba_ack),
        .ba_dok      (ba_dok),
        .ba_rdy      (ba_rdy),
        .gnt         (gnt),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int idx, input logic rd, input logic wr,
                         input logic [AW-1:0] a, input logic [15:0] d, input logic [1:0] m);
        c_rd[idx]             = rd;
        c_wr[idx]             = wr;
        c_addr[idx*AW +: AW]  = a;
        c_din[idx*16 +: 16]   = d;
        c_din_m[idx*2 +: 2]   = m;
    endtask

    task automatic expect_gnt(input int idx, input logic [AW-1:0] a, input logic wr,
                              input logic [15:0] d, input logic [1:0] m);
        exp_t e;
        e.gnt  = 4'(1 << idx);
        e.addr = a;
        e.wr   = wr;
        e.din  = d;
        e.dm   = m;
        sb.push_back(e);
    endtask

    // One clock after the grant becomes visible, check it against the scoreboard, then ack after ack_dly cycles.
    task automatic grant_and_ack(input int ack_dly, input bit drop, output logic [3:0] g);
        exp_t e;
        @(negedge clk);
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL sb_empty observed=empty expected=entry");
            e = '0;
        end else begin
            e = sb.pop_front();
        end
        g = e.gnt;
        chk("gnt", gnt, e.gnt);
        chk("ba_addr", ba_addr, e.addr);
        chk("ba_wr", ba_wr, e.wr);
        chk("ba_rd", ba_rd, !e.wr);
        chk("ba_din", ba_din, e.din);
        chk("ba_din_m", ba_din_m, e.dm);
        #1;
        chk("c_ack_before", c_ack, 4'b0000);
        repeat (ack_dly) @(negedge clk);
        chk("ba_req_held", {ba_rd, ba_wr}, {!e.wr, e.wr});
        ba_ack = 1'b1;
        #1;
        chk("c_ack", c_ack, e.gnt);
        chk("c_dok_issue", c_dok, 4'b0000);
        @(negedge clk);
        ba_ack = 1'b0;
        chk("ba_req_clr", {ba_rd, ba_wr}, 2'b00);
        if (drop) begin
            c_rd = c_rd & ~e.gnt;
            c_wr = c_wr & ~e.gnt;
        end
    endtask

    // WAIT phase: dok on odd cycles, a stray ack that must be swallowed, then rdy and the bubble.
    task automatic wait_done(input logic [3:0] g, input int wait_cyc);
        for (int i = 0; i < wait_cyc; i++) begin
            ba_dok = (i % 2 == 1);
            ba_ack = (i == 2);
            #1;
            chk("c_dok", c_dok, ba_dok ? g : 4'b0000);
            chk("c_ack_wait", c_ack, 4'b0000);
            chk("c_rdy_early", c_rdy, 4'b0000);
            @(negedge clk);
        end
        ba_dok = 1'b0;
        ba_ack = 1'b0;
        ba_rdy = 1'b1;
        #1;
        chk("c_rdy", c_rdy, g);
        chk("gnt_hold", gnt, g);
        @(negedge clk);
        ba_rdy = 1'b0;
        #1;
        chk("bubble_gnt", gnt, 4'b0000);
        chk("c_rdy_off", c_rdy, 4'b0000);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [3:0] g;
        rst     = 1'b1;
        c_addr  = '0;
        c_rd    = '0;
        c_wr    = '0;
        c_din   = '0;
        c_din_m = '0;
        ba_ack  = 1'b0;
        ba_dok  = 1'b0;
        ba_rdy  = 1'b0;
        #3;
        chk("rst_gnt", gnt, 4'b0000);
        chk("rst_ba_req", {ba_rd, ba_wr}, 2'b00);
        chk("rst_ba_addr", ba_addr, 0);
        chk("rst_ba_din", {ba_din, ba_din_m}, 0);
        chk("rst_c_out", {c_ack, c_dok, c_rdy}, 0);
        chk("rst_timeout_err", timeout_err, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Single read on client 2
        drive(2, 1'b1, 1'b0, 22'h12340, 16'h1111, 2'b00);
        expect_gnt(2, 22'h12340, 1'b0, 16'h1111, 2'b00);
        grant_and_ack(3, 1'b1, g);
        wait_done(g, 7);

        // ptr is now 3: with clients 2 and 3 requesting, 3 wins, then 2
        drive(2, 1'b1, 1'b0, 22'h00222, 16'h2222, 2'b01);
        drive(3, 1'b1, 1'b0, 22'h00333, 16'h3333, 2'b10);
        expect_gnt(3, 22'h00333, 1'b0, 16'h3333, 2'b10);
        expect_gnt(2, 22'h00222, 1'b0, 16'h2222, 2'b01);
        grant_and_ack(1, 1'b1, g);
        wait_done(g, 2);
        grant_and_ack(0, 1'b1, g);
        wait_done(g, 2);

        // Write masking: client 0 may write, client 1 is forced to read
        drive(0, 1'b0, 1'b1, 22'h00AAA, 16'hA55A, 2'b10);
        expect_gnt(0, 22'h00AAA, 1'b1, 16'hA55A, 2'b10);
        grant_and_ack(2, 1'b1, g);
        wait_done(g, 3);
        drive(1, 1'b0, 1'b1, 22'h00BBB, 16'h5AA5, 2'b01);
        expect_gnt(1, 22'h00BBB, 1'b0, 16'h5AA5, 2'b01);
        grant_and_ack(1, 1'b1, g);
        wait_done(g, 3);

        // rd and wr together on a write-enabled client: write wins
        drive(0, 1'b1, 1'b1, 22'h3FFFF, 16'hC3C3, 2'b11);
        expect_gnt(0, 22'h3FFFF, 1'b1, 16'hC3C3, 2'b11);
        grant_and_ack(0, 1'b1, g);
        wait_done(g, 1);

        // Watchdog: client 1 read, bank never returns rdy; client 2 pending
        drive(1, 1'b1, 1'b0, 22'h01111, 16'h0101, 2'b00);
        expect_gnt(1, 22'h01111, 1'b0, 16'h0101, 2'b00);
        grant_and_ack(0, 1'b1, g);
        drive(2, 1'b1, 1'b0, 22'h02222, 16'h0202, 2'b00);
        expect_gnt(2, 22'h02222, 1'b0, 16'h0202, 2'b00);
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("wd_no_rdy", c_rdy, 4'b0000);
            chk("wd_err_low", timeout_err, 1'b0);
            @(negedge clk);
        end
        #1;
        chk("wd_rdy_pulse", c_rdy, g);
        chk("wd_gnt_hold", gnt, g);
        @(negedge clk);
        #1;
        chk("wd_err_set", timeout_err, 1'b1);
        chk("wd_idle_gnt", gnt, 4'b0000);
        chk("wd_rdy_once", c_rdy, 4'b0000);
        grant_and_ack(1, 1'b1, g);
        wait_done(g, 2);
        chk("wd_err_sticky", timeout_err, 1'b1);

        // Reset in the middle of a dok burst
        drive(3, 1'b1, 1'b0, 22'h3ABCD, 16'h3030, 2'b00);
        expect_gnt(3, 22'h3ABCD, 1'b0, 16'h3030, 2'b00);
        grant_and_ack(1, 1'b1, g);
        ba_dok = 1'b1;
        #1;
        chk("mid_dok", c_dok, g);
        @(negedge clk);
        drive(1, 1'b1, 1'b0, 22'h00101, 16'h0011, 2'b00);
        drive(3, 1'b1, 1'b0, 22'h00303, 16'h0033, 2'b00);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_gnt", gnt, 4'b0000);
        chk("arst_ba_req", {ba_rd, ba_wr}, 2'b00);
        chk("arst_c_out", {c_ack, c_dok, c_rdy}, 0);
        chk("arst_timeout_err", timeout_err, 1'b0);
        chk("arst_ba_addr", ba_addr, 0);
        ba_dok = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        expect_gnt(1, 22'h00101, 1'b0, 16'h0011, 2'b00);
        expect_gnt(3, 22'h00303, 1'b0, 16'h0033, 2'b00);
        grant_and_ack(0, 1'b1, g);
        wait_done(g, 1);
        grant_and_ack(0, 1'b1, g);
        wait_done(g, 1);

        // Contention: all four read from reset; order 0,1,2,3,0 with one bubble each
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(i, 1'b1, 1'b0, 22'(32'h1000 * (i + 1)), 16'(i + 16'h40), 2'(i));
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            expect_gnt(i % 4, 22'(32'h1000 * ((i % 4) + 1)), 1'b0, 16'((i % 4) + 16'h40), 2'(i % 4));
        end
        for (int i = 0; i < 5; i++) begin
            grant_and_ack(1, 1'b0, g);
            wait_done(g, 3);
        end
        c_rd = 4'b0000;
        @(negedge clk);
        chk("end_idle", gnt, 4'b0000);
        chk("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/jtframe_sdram64_arb4.md
Name: jtframe_sdram64_arb4

Overview:
- Four-client arbiter that shares one bank port of jtframe_sdram64 (rd/wr/addr/din/din_m in; ack/dok/rdy out).
- Lets several CPU, DMA or graphics fetchers share one SDRAM bank without per-bank address partitioning in the core.
- Round-robin grant with one outstanding transaction. The bank's ack/dok/rdy are routed back to the granted client only.
- A watchdog recovers the arbiter if the bank never returns rdy.

Parameters:
- AW, 22, address width per client and to bank port
- WR_MASK, 4'b1111, bit n=1 lets client n write; a write from a client with its bit at 0 is issued as a read
- TIMEOUT, 1023, max cycles from bank ack to rdy before the watchdog fires (10-bit counter)

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- c_addr  in  4*AW  client addresses, client n at [n*AW +: AW]
- c_rd  in  4  read requests
- c_wr  in  4  write requests
- c_din  in  64  write data, client n at [n*16 +: 16]
- c_din_m  in  8  write byte masks, client n at [n*2 +: 2], 1 = byte not written
- c_ack  out  4  per-client ack
- c_dok  out  4  per-client data-valid strobe
- c_rdy  out  4  per-client transaction done
- ba_addr  out  AW  to bank port
- ba_rd  out  1  bank read request
- ba_wr  out  1  bank write request
- ba_din  out  16  bank write data
- ba_din_m  out  2  bank write mask
- ba_ack  in  1  bank ack
- ba_dok  in  1  bank data-valid strobe
- ba_rdy  in  1  bank done
- gnt  out  4  one-hot current grant, 0 when idle
- timeout_err  out  1  sticky watchdog flag

Behaviour:
- Reset is asynchronous, active-high; clock is clk.
- Reset values:
  - state IDLE
  - gnt=0, ba_rd=0, ba_wr=0, ba_addr=0, ba_din=0, ba_din_m=0
  - round-robin pointer ptr=0
  - watchdog counter=0, timeout_err=0
- Client request: req[n] = c_rd[n] | c_wr[n]. A client holds its request and operands stable until its c_ack.
- State IDLE:
  - At the posedge where any req is high, pick the first requester scanning ptr, ptr+1, … mod 4.
  - Register gnt and the chosen client's addr, din and din_m into ba_*.
  - ba_wr = c_wr[n] & WR_MASK[n]; ba_rd = !ba_wr. If rd and wr are both high, write wins.
  - Go to ISSUE. Bank request is visible one cycle after the client request is first sampled.
- State ISSUE:
  - ba_rd/ba_wr held.
  - c_ack = {4{ba_ack}} & gnt, combinational.
  - On the posedge with ba_ack=1: clear ba_rd/ba_wr, clear the counter, go to WAIT.
  - No timeout in ISSUE, because the bank may be busy refreshing.
- State WAIT:
  - c_dok = {4{ba_dok}} & gnt and c_rdy = {4{ba_rdy}} & gnt, combinational, zero latency.
  - On ba_rdy: ptr = index(gnt)+1 mod 4, gnt=0, go to IDLE. One bubble cycle is required before the next grant.
  - ba_ack arriving in WAIT is ignored and not forwarded.
  - Counter increments each cycle. When counter reaches TIMEOUT without rdy: set timeout_err, pulse c_rdy of the granted client for one cycle, gnt=0, advance ptr, go to IDLE.
- Outside WAIT, c_dok and c_rdy are 0. Outside ISSUE, c_ack is 0.
- A client dropping its request before grant is simply not granted. A request dropped after grant does not cancel the bank transaction.
- ba_rdy in the same cycle as a new req: the new req is granted on the next IDLE cycle, with ptr already advanced.
- timeout_err clears only on rst.
- rst mid-transaction aborts immediately: all outputs go to reset values. The bank controller is reset by the same rst.

Test Plan:
- Single read: c_rd=4'b0100, c_addr[2]=22'h12340, bank acks after 3 cycles and gives rdy 8 cycles later. Required: gnt=4'b0100 one cycle after request; ba_addr=22'h12340; c_ack[2] is the only ack; c_dok[2]/c_rdy[2] mirror the bank; ptr=3 afterwards.
- Contention: c_rd=4'b1111 held from reset. Required: grant order 0,1,2,3,0, with exactly one bubble between rdy and the next gnt.
- Write masking: WR_MASK=4'b0001. c_wr[0]=1 with din=16'hA55A, din_m=2'b10 gives ba_wr=1, ba_din=16'hA55A, ba_din_m=2'b10. c_wr[1]=1 gives ba_rd=1, ba_wr=0.
- Simultaneous rd and wr on client 0 with WR_MASK bit set → ba_wr=1, ba_rd=0.
- Watchdog with TIMEOUT=16: after ack, ba_rdy is never asserted. Required: after 16 cycles in WAIT, timeout_err=1, a one-cycle c_rdy for the granted client, then a return to IDLE; a pending request is granted next.
- Reset mid-WAIT: assert rst during ba_dok bursts. Required: gnt, ba_rd, ba_wr, c_* outputs and timeout_err all 0 asynchronously; after release, the first grant goes to the lowest requesting index, since ptr=0.
